instr_fetch_ctrl: RTL and testbench

//   Sequences instruction_memory: owns the PC, drives the memory's combinational read address,
//   and registers {pc, instruction} into a one-entry valid/ready stage toward decode.

---
 rtl/instr_fetch_ctrl_pkg.sv | 13 +
 rtl/instr_fetch_ctrl_if.sv | 26 ++
 rtl/instr_fetch_ctrl_out_reg.sv | 33 +++
 rtl/instruction_memory.sv | 41 ++++
 rtl/instr_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FAULT
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Valid/ready bus carrying {pc, instruction} from fetch to decode.
interface instr_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();

    logic                     if_valid;
    logic                     if_ready;
    logic [ADDRESS_WIDTH-1:0] if_pc;
    logic [DATA_WIDTH-1:0]    if_instr;

    modport master (
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );

endinterface

// File: rtl/instr_fetch_ctrl_out_reg.sv
// One-entry valid/ready holding register for the fetched {pc, instr} pair.
module fetch_out_reg #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     flush,
    input  logic                     pop,
    input  logic [ADDRESS_WIDTH-1:0] load_pc,
    input  logic [DATA_WIDTH-1:0]    load_instr,
    output logic                     valid,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0]    out_instr
);

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            out_pc    <= load_pc;
            out_instr <= load_instr;
        end else if (flush || pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Combinational instruction ROM holding the base test program; unlisted words read as NOP.
module instruction_memory
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256
) (
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    instruction
);

    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE * INSTR_BYTES);

    logic [IDX_W-1:0] idx;
    logic             in_range;

    assign idx      = address[IDX_W+1:2];
    assign in_range = ({1'b0, address} < MEM_LIMIT) && (address[1:0] == 2'b00);

    always_comb begin
        instruction = DATA_WIDTH'(NOP_INSTR);
        if (in_range) begin
            case (idx)
                IDX_W'(0): instruction = DATA_WIDTH'(32'h00500093);
                IDX_W'(1): instruction = DATA_WIDTH'(32'h00300113);
                IDX_W'(2): instruction = DATA_WIDTH'(32'h002081b3);
                IDX_W'(3): instruction = DATA_WIDTH'(32'h40218233);
                IDX_W'(4): instruction = DATA_WIDTH'(32'h00302023);
                IDX_W'(5): instruction = DATA_WIDTH'(32'h00002283);
                IDX_W'(6): instruction = DATA_WIDTH'(32'hfff08093);
                IDX_W'(7): instruction = DATA_WIDTH'(32'h00008463);
                IDX_W'(8): instruction = DATA_WIDTH'(32'hff9ff06f);
                IDX_W'(9): instruction = DATA_WIDTH'(32'h0000006f);
                default:   instruction = DATA_WIDTH'(NOP_INSTR);
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory and feeds decode through a
// one-entry stage, with redirect, backpressure and sticky fault handling.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                   DATA_WIDTH    = 32,
    parameter int                   ADDRESS_WIDTH = 32,
    parameter int                   MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [ADDRESS_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]    imem_instruction,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    instr_fetch_ctrl_if.master       decode,
    output logic                     fault,
    output logic [ADDRESS_WIDTH-1:0] fault_pc,
    output logic [31:0]              fetch_count
);

    localparam logic [ADDRESS_WIDTH:0] PC_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE * INSTR_BYTES);

    fetch_state_t             state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     out_valid;
    logic [ADDRESS_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic                     handshake;
    logic                     slot_free;
    logic                     pc_legal;
    logic                     redirect_take;
    logic                     fetch_try;
    logic                     capture;
    logic                     fault_hit;

    assign imem_address  = pc;
    assign handshake     = out_valid && decode.if_ready;
    assign slot_free     = !out_valid || decode.if_ready;
    assign pc_legal      = (pc[1:0] == 2'b00) && ({1'b0, pc} < PC_LIMIT);
    assign redirect_take = redirect_valid && (state != FAULT);
    // A fetch attempt is what exposes a bad PC, so faults only arise from FETCH.
    assign fetch_try     = (state == FETCH) && en && slot_free && !redirect_take;
    assign capture       = fetch_try && pc_legal;
    assign fault_hit     = fetch_try && !pc_legal;

    assign decode.if_valid = out_valid;
    assign decode.if_pc    = out_pc;
    assign decode.if_instr = out_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (redirect_take) begin
                pc <= redirect_pc;
            end else if (capture) begin
                pc <= pc + ADDRESS_WIDTH'(INSTR_BYTES);
            end

            if (fault_hit) begin
                fault    <= 1'b1;
                fault_pc <= pc;
            end

            case (state)
                IDLE:    if (en) state <= FETCH;
                FETCH: begin
                    if (fault_hit) begin
                        state <= FAULT;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_out_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .flush     (redirect_take),
        .pop       (handshake),
        .load_pc   (pc),
        .load_instr(imem_instruction),
        .valid     (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl driving the real instruction_memory.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks_total;
    int checks_passed;

    instr_fetch_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dec ();

    instruction_memory #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE     (256)
    ) u_mem (
        .address    (imem_address),
        .instruction(imem_instruction)
    );

    instr_fetch_ctrl #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE     (256),
        .RESET_PC     (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .decode          (dec),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst            = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec.if_ready   = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;

        // Reset state and straight-line fetch at full throughput
        apply_reset(2);
        check_output("rst_valid", {31'b0, dec.if_valid}, 32'h0);
        check_output("rst_pc", dec.if_pc, 32'h0);
        check_output("rst_instr", dec.if_instr, 32'h0);
        check_output("rst_fault", {31'b0, fault}, 32'h0);
        check_output("rst_fault_pc", fault_pc, 32'h0);
        check_output("rst_count", fetch_count, 32'h0);
        check_output("rst_imem_addr", imem_address, 32'h0);
        en           = 1'b1;
        dec.if_ready = 1'b1;
        tick();
        check_output("idle_to_fetch_valid", {31'b0, dec.if_valid}, 32'h0);
        tick();
        check_output("t1_pc0", dec.if_pc, 32'h0);
        check_output("t1_instr0", dec.if_instr, 32'h00500093);
        tick();
        check_output("t1_pc4", dec.if_pc, 32'h4);
        check_output("t1_instr4", dec.if_instr, 32'h00300113);
        tick();
        check_output("t1_pc8", dec.if_pc, 32'h8);
        check_output("t1_instr8", dec.if_instr, 32'h002081b3);
        tick();
        check_output("t1_count3", fetch_count, 32'd3);

        // Backpressure holds the entry at 0x4 and freezes the PC
        apply_reset(1);
        en           = 1'b1;
        dec.if_ready = 1'b1;
        tick();
        tick();
        tick();
        check_output("t2_pc4", dec.if_pc, 32'h4);
        dec.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_hold_valid", {31'b0, dec.if_valid}, 32'h1);
            check_output("t2_hold_pc", dec.if_pc, 32'h4);
            check_output("t2_hold_instr", dec.if_instr, 32'h00300113);
            check_output("t2_hold_imem", imem_address, 32'h8);
        end
        dec.if_ready = 1'b1;
        tick();
        check_output("t2_release_pc", dec.if_pc, 32'h8);

        // Redirect to 0x20 flushes the pending 0xC entry
        tick();
        check_output("t3_pending_pc", dec.if_pc, 32'hC);
        dec.if_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        check_output("t3_flush_valid", {31'b0, dec.if_valid}, 32'h0);
        check_output("t3_redir_imem", imem_address, 32'h20);
        redirect_valid = 1'b0;
        dec.if_ready   = 1'b1;
        tick();
        check_output("t3_pc20", dec.if_pc, 32'h20);
        check_output("t3_instr20", dec.if_instr, 32'hff9ff06f);
        check_output("t3_count", fetch_count, 32'd3);

        // Misaligned redirect faults on its first fetch; later redirects ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2;
        tick();
        check_output("t4_redir_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        tick();
        check_output("t4_fault", {31'b0, fault}, 32'h1);
        check_output("t4_fault_pc", fault_pc, 32'h2);
        check_output("t4_valid", {31'b0, dec.if_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_output("t4_ignored_imem", imem_address, 32'h2);
        check_output("t4_ignored_valid", {31'b0, dec.if_valid}, 32'h0);
        check_output("t4_sticky_fault", {31'b0, fault}, 32'h1);

        // Last legal word then out-of-range fault at 0x400
        apply_reset(1);
        en             = 1'b1;
        dec.if_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_output("t5_pc3fc", dec.if_pc, 32'h3FC);
        check_output("t5_instr3fc", dec.if_instr, 32'h00000013);
        check_output("t5_no_fault_yet", {31'b0, fault}, 32'h0);
        tick();
        check_output("t5_count", fetch_count, 32'd1);
        check_output("t5_fault", {31'b0, fault}, 32'h1);
        check_output("t5_fault_pc", fault_pc, 32'h400);
        check_output("t5_valid", {31'b0, dec.if_valid}, 32'h0);

        // Reset mid-stream discards the pending entry at 0x10
        apply_reset(1);
        en           = 1'b1;
        dec.if_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_output("t6_pc10", dec.if_pc, 32'h10);
        check_output("t6_valid", {31'b0, dec.if_valid}, 32'h1);
        check_output("t6_count", fetch_count, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t6_rst_valid", {31'b0, dec.if_valid}, 32'h0);
        check_output("t6_rst_fault", {31'b0, fault}, 32'h0);
        check_output("t6_rst_count", fetch_count, 32'h0);
        tick();
        tick();
        check_output("t6_restart_pc", dec.if_pc, 32'h0);
        check_output("t6_restart_valid", {31'b0, dec.if_valid}, 32'h1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
